// File: rtl/ysyx_23060201_gpr_wb_arbiter_if.sv
// Bus bundle between IDU/EXU/LSU, the writeback arbiter and the GPR file.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface ysyx_23060201_gpr_wb_arbiter_if #(
    parameter int unsigned GPR_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH     = 32
);
    logic                      id_valid;
    logic                      id_ready;
    logic [1:0]                id_ren;
    logic [GPR_ADDR_WIDTH-1:0] id_rs1;
    logic [GPR_ADDR_WIDTH-1:0] id_rs2;
    logic                      id_rd_wen;
    logic [GPR_ADDR_WIDTH-1:0] id_rd;

    logic                      alu_valid;
    logic                      alu_ready;
    logic [GPR_ADDR_WIDTH-1:0] alu_waddr;
    logic [DATA_WIDTH-1:0]     alu_wdata;

    logic                      lsu_valid;
    logic                      lsu_ready;
    logic [GPR_ADDR_WIDTH-1:0] lsu_waddr;
    logic [DATA_WIDTH-1:0]     lsu_wdata;

    logic [1:0]                gpr_ren;
    logic [GPR_ADDR_WIDTH-1:0] gpr_raddr1;
    logic [GPR_ADDR_WIDTH-1:0] gpr_raddr2;
    logic                      gpr_wen;
    logic [GPR_ADDR_WIDTH-1:0] gpr_waddr;
    logic [DATA_WIDTH-1:0]     gpr_wdata;

    modport slave (
        input  id_valid, id_ren, id_rs1, id_rs2, id_rd_wen, id_rd,
        input  alu_valid, alu_waddr, alu_wdata,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        output id_ready, alu_ready, lsu_ready,
        output gpr_ren, gpr_raddr1, gpr_raddr2, gpr_wen, gpr_waddr, gpr_wdata
    );

    modport master (
        output id_valid, id_ren, id_rs1, id_rs2, id_rd_wen, id_rd,
        output alu_valid, alu_waddr, alu_wdata,
        output lsu_valid, lsu_waddr, lsu_wdata,
        input  id_ready, alu_ready, lsu_ready,
        input  gpr_ren, gpr_raddr1, gpr_raddr2, gpr_wen, gpr_waddr, gpr_wdata
    );
endinterface

// File: rtl/ysyx_23060201_gpr_wb_arbiter.sv
// GPR writeback arbiter (ALU/LSU round-robin) with busy scoreboard and issue hazard gating.
// Optional YSYX_23060201_GPR_WB_CHECK_EN adds a sticky wb_err protocol checker output.
module ysyx_23060201_gpr_wb_arbiter #(
    parameter int unsigned GPR_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef YSYX_23060201_GPR_WB_CHECK_EN
    output logic wb_err,
`endif
    ysyx_23060201_gpr_wb_arbiter_if.slave bus
);
    localparam int unsigned NREGS = 2 ** GPR_ADDR_WIDTH;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_e;

    rr_e                       rr_q, rr_d;
    logic [NREGS-1:0]          busy_q, busy_d;
    logic                      wen_q, wen_d;
    logic [GPR_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;

    logic                      hazard;
    logic                      fire;
    logic                      alu_gnt, lsu_gnt, gnt_any;
    logic [GPR_ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]     sel_data;

    // Issue gating against RAW on sources and WAW on the destination
    always_comb begin
        hazard = (bus.id_ren[0] & busy_q[bus.id_rs1])
               | (bus.id_ren[1] & busy_q[bus.id_rs2])
               | (bus.id_rd_wen & busy_q[bus.id_rd]);
        fire   = bus.id_valid & ~hazard;
    end

    assign bus.id_ready   = ~hazard;
    assign bus.gpr_ren    = fire ? bus.id_ren : 2'b00;
    assign bus.gpr_raddr1 = bus.id_rs1;
    assign bus.gpr_raddr2 = bus.id_rs2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= RR_ALU;
            busy_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Arbitration, write stage and scoreboard next state
    always_comb begin
        rr_d    = rr_q;
        busy_d  = busy_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;

        alu_gnt = bus.alu_valid & (~bus.lsu_valid | (rr_q == RR_ALU));
        lsu_gnt = bus.lsu_valid & (~bus.alu_valid | (rr_q == RR_LSU));
        gnt_any = alu_gnt | lsu_gnt;
        sel_addr = lsu_gnt ? bus.lsu_waddr : bus.alu_waddr;
        sel_data = lsu_gnt ? bus.lsu_wdata : bus.alu_wdata;

        if (bus.alu_valid && bus.lsu_valid) begin
            rr_d = (rr_q == RR_ALU) ? RR_LSU : RR_ALU;
        end

        if (gnt_any && (sel_addr != '0)) begin
            wen_d   = 1'b1;
            waddr_d = sel_addr;
            wdata_d = sel_data;
        end

        // Clear on commit first so a same-index issue set takes priority
        if (wen_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (fire && bus.id_rd_wen) begin
            busy_d[bus.id_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.lsu_ready = lsu_gnt;
    assign bus.gpr_wen   = wen_q;
    assign bus.gpr_waddr = waddr_q;
    assign bus.gpr_wdata = wdata_q;

`ifdef YSYX_23060201_GPR_WB_CHECK_EN
    logic err_wb, err_issue;

    always_comb begin
        err_wb    = gnt_any && (sel_addr != '0) && !busy_q[sel_addr];
        err_issue = fire && bus.id_rd_wen && (bus.id_rd != '0)
                 && wen_q && (waddr_q == bus.id_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (err_wb || err_issue) begin
            wb_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && err_wb) begin
            $display("gpr_wb_arbiter: writeback to non-busy x%0d", sel_addr);
        end
        if (!rst && err_issue) begin
            $display("gpr_wb_arbiter: issue rd x%0d collides with commit", bus.id_rd);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_ysyx_23060201_gpr_wb_arbiter.sv
// Directed, table-driven bench for the GPR writeback arbiter and scoreboard.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ysyx_23060201_gpr_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_23060201_gpr_wb_arbiter_if #(.GPR_ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

`ifdef YSYX_23060201_GPR_WB_CHECK_EN
    logic wb_err;
    ysyx_23060201_gpr_wb_arbiter #(.GPR_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .wb_err(wb_err), .bus(bus));
`else
    ysyx_23060201_gpr_wb_arbiter #(.GPR_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct {
        logic        idv;
        logic [1:0]  ren;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rdw;
        logic [4:0]  rd;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_rdy;
        logic [1:0]  e_ren;
        logic        e_ar;
        logic        e_lr;
        logic        e_wen;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid  = v.idv;
        bus.id_ren    = v.ren;
        bus.id_rs1    = v.rs1;
        bus.id_rs2    = v.rs2;
        bus.id_rd_wen = v.rdw;
        bus.id_rd     = v.rd;
        bus.alu_valid = v.av;
        bus.alu_waddr = v.aa;
        bus.alu_wdata = v.ad;
        bus.lsu_valid = v.lv;
        bus.lsu_waddr = v.la;
        bus.lsu_wdata = v.ld;
    endtask

    task automatic idle();
        vec_t z;
        z = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
              1'b0, 5'd0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        drive(z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        idv  ren    rs1  rs2  rdw  rd   av   aa   ad            lv   la   ld            rdy  ren    ar   lr   wen  wa   wd
        vecs[0]  = '{1'b1,2'b00,5'd0,5'd0,1'b1,5'd5,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,2'b00,1'b0,1'b0,1'b0,5'd0,32'h0};
        vecs[1]  = '{1'b1,2'b01,5'd5,5'd0,1'b0,5'd0,1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,     1'b0,2'b00,1'b1,1'b0,1'b0,5'd0,32'h0};
        vecs[2]  = '{1'b1,2'b01,5'd5,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,2'b00,1'b0,1'b0,1'b1,5'd5,32'hDEADBEEF};
        vecs[3]  = '{1'b1,2'b01,5'd5,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,2'b01,1'b0,1'b0,1'b0,5'd0,32'h0};
        vecs[4]  = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b1,5'd3,32'h33,       1'b1,5'd4,32'h44,    1'b1,2'b00,1'b1,1'b0,1'b0,5'd0,32'h0};
        vecs[5]  = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b1,5'd3,32'h33,       1'b1,5'd4,32'h44,    1'b1,2'b00,1'b0,1'b1,1'b1,5'd3,32'h33};
        vecs[6]  = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b1,5'd3,32'h33,       1'b1,5'd4,32'h44,    1'b1,2'b00,1'b1,1'b0,1'b1,5'd4,32'h44};
        vecs[7]  = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b1,5'd3,32'h33,       1'b1,5'd4,32'h44,    1'b1,2'b00,1'b0,1'b1,1'b1,5'd3,32'h33};
        vecs[8]  = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,2'b00,1'b0,1'b0,1'b1,5'd4,32'h44};
        vecs[9]  = '{1'b1,2'b00,5'd0,5'd0,1'b1,5'd0,1'b1,5'd0,32'h1234,     1'b0,5'd0,32'h0,     1'b1,2'b00,1'b1,1'b0,1'b0,5'd0,32'h0};
        vecs[10] = '{1'b1,2'b11,5'd0,5'd0,1'b1,5'd0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,2'b11,1'b0,1'b0,1'b0,5'd0,32'h0};
        vecs[11] = '{1'b1,2'b00,5'd0,5'd0,1'b1,5'd7,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,2'b00,1'b0,1'b0,1'b0,5'd0,32'h0};
        vecs[12] = '{1'b1,2'b00,5'd0,5'd0,1'b1,5'd7,1'b0,5'd0,32'h0,        1'b1,5'd7,32'h77,    1'b0,2'b00,1'b0,1'b1,1'b0,5'd0,32'h0};
        vecs[13] = '{1'b1,2'b00,5'd0,5'd0,1'b1,5'd7,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,2'b00,1'b0,1'b0,1'b1,5'd7,32'h77};
        vecs[14] = '{1'b1,2'b00,5'd0,5'd0,1'b1,5'd7,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,2'b00,1'b0,1'b0,1'b0,5'd0,32'h0};
        vecs[15] = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b1,5'd2,32'h22,       1'b0,5'd0,32'h0,     1'b1,2'b00,1'b1,1'b0,1'b0,5'd0,32'h0};
        vecs[16] = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b1,5'd3,32'h30,       1'b1,5'd4,32'h40,    1'b1,2'b00,1'b1,1'b0,1'b1,5'd2,32'h22};
        vecs[17] = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,        1'b1,5'd4,32'h41,    1'b1,2'b00,1'b0,1'b1,1'b1,5'd3,32'h30};
        vecs[18] = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b1,5'd3,32'h31,       1'b1,5'd4,32'h42,    1'b1,2'b00,1'b0,1'b1,1'b1,5'd4,32'h41};
        vecs[19] = '{1'b1,2'b10,5'd0,5'd7,1'b0,5'd0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,2'b00,1'b0,1'b0,1'b1,5'd4,32'h42};
        vecs[20] = '{1'b0,2'b10,5'd0,5'd7,1'b0,5'd0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,2'b00,1'b0,1'b0,1'b0,5'd0,32'h0};
        vecs[21] = '{1'b0,2'b00,5'd0,5'd0,1'b0,5'd0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,2'b00,1'b0,1'b0,1'b0,5'd0,32'h0};

        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gpr_wen",   0, 32'(bus.gpr_wen),   32'h0);
        check("rst_gpr_waddr", 0, 32'(bus.gpr_waddr), 32'h0);
        check("rst_gpr_wdata", 0, bus.gpr_wdata,      32'h0);
        check("rst_id_ready",  0, 32'(bus.id_ready),  32'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check("id_ready",   i, 32'(bus.id_ready),   32'(vecs[i].e_rdy));
            check("gpr_ren",    i, 32'(bus.gpr_ren),    32'(vecs[i].e_ren));
            check("gpr_raddr1", i, 32'(bus.gpr_raddr1), 32'(vecs[i].rs1));
            check("gpr_raddr2", i, 32'(bus.gpr_raddr2), 32'(vecs[i].rs2));
            check("alu_ready",  i, 32'(bus.alu_ready),  32'(vecs[i].e_ar));
            check("lsu_ready",  i, 32'(bus.lsu_ready),  32'(vecs[i].e_lr));
            check("gpr_wen",    i, 32'(bus.gpr_wen),    32'(vecs[i].e_wen));
            if (vecs[i].e_wen) begin
                check("gpr_waddr", i, 32'(bus.gpr_waddr), 32'(vecs[i].e_wa));
                check("gpr_wdata", i, bus.gpr_wdata,      vecs[i].e_wd);
            end
        end

        // Reset during a pending write: busy r9 set, rr_ptr left at LSU
        @(negedge clk);
        idle();
        bus.id_valid = 1'b1; bus.id_rd_wen = 1'b1; bus.id_rd = 5'd9;
        bus.alu_valid = 1'b1; bus.alu_waddr = 5'd10; bus.alu_wdata = 32'hAA;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd11; bus.lsu_wdata = 32'hBB;
        #1;
        check("pre_rst_alu_ready", 0, 32'(bus.alu_ready), 32'h1);
        check("pre_rst_lsu_ready", 0, 32'(bus.lsu_ready), 32'h0);
        check("pre_rst_id_ready",  0, 32'(bus.id_ready),  32'h1);
        @(negedge clk);
        idle();
        #1;
        check("pre_rst_gpr_wen",   0, 32'(bus.gpr_wen),   32'h1);
        check("pre_rst_gpr_waddr", 0, 32'(bus.gpr_waddr), 32'd10);
        rst = 1'b1;
        #1;
        check("async_rst_gpr_wen",   0, 32'(bus.gpr_wen),   32'h0);
        check("async_rst_gpr_waddr", 0, 32'(bus.gpr_waddr), 32'h0);
        check("async_rst_gpr_wdata", 0, bus.gpr_wdata,      32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.id_valid = 1'b1; bus.id_ren = 2'b11; bus.id_rs1 = 5'd9; bus.id_rs2 = 5'd7;
        bus.alu_valid = 1'b1; bus.alu_waddr = 5'd12; bus.alu_wdata = 32'hC12;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd13; bus.lsu_wdata = 32'hC13;
        #1;
        check("post_rst_id_ready",  0, 32'(bus.id_ready),  32'h1);
        check("post_rst_gpr_ren",   0, 32'(bus.gpr_ren),   32'h3);
        check("post_rst_alu_ready", 0, 32'(bus.alu_ready), 32'h1);
        check("post_rst_lsu_ready", 0, 32'(bus.lsu_ready), 32'h0);
        @(negedge clk);
        idle();
        #1;
        check("post_rst_gpr_wen",   0, 32'(bus.gpr_wen),   32'h1);
        check("post_rst_gpr_waddr", 0, 32'(bus.gpr_waddr), 32'd12);
        check("post_rst_gpr_wdata", 0, bus.gpr_wdata,      32'hC12);

`ifdef YSYX_23060201_GPR_WB_CHECK_EN
        // Writeback to a register nobody claimed must raise a sticky error
        rst = 1'b1;
        #1;
        check("chk_wb_err_rst", 0, 32'(wb_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_waddr = 5'd6; bus.alu_wdata = 32'h66;
        @(negedge clk);
        idle();
        #1;
        check("chk_wb_err_set", 0, 32'(wb_err), 32'h1);
        repeat (3) @(negedge clk);
        #1;
        check("chk_wb_err_held", 0, 32'(wb_err), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
